// File: rtl/uart_pkg.sv
// Shared types and constants for the UART bus responder.
package uart_pkg;

   localparam int unsigned DEFAULT_CLK_DIV = 434;
   localparam int unsigned BITS_PER_CHAR   = 8;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   // Receiver waits this long after the start edge to land mid-bit.
   function automatic logic [15:0] half_bit(input logic [15:0] div);
      return div >> 1;
   endfunction

endpackage

// File: rtl/uart_bus_responder_sync_edge.sv
// Two-flop synchronizer with a third flop for rise/fall pulse generation.
module sync_edge #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Synchronizer chain plus one delayed copy for edge detection
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
         prev_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign q_o    = sync_q;
   assign rise_o = sync_q & ~prev_q;
   assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/uart_bus_responder.sv
// UART responder on the memory controller's rdn/wrn handshake: one-byte
// transmit holding register plus shifter, and an 8N1 receiver with holding register.
module uart_bus_responder
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV,
   parameter int unsigned DATA_W  = BITS_PER_CHAR
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              rdn,
   input  logic              wrn,
   input  logic [DATA_W-1:0] bus_din,
   output logic [DATA_W-1:0] bus_dout,
   output logic              bus_oe,
   output logic              data_ready,
   output logic              tbre,
   output logic              tsre,
   output logic              txd,
   input  logic              rxd,
   output logic              rx_overrun,
   output logic              rx_frame_err
);

   localparam logic [15:0] DIV_M1   = 16'(CLK_DIV - 1);
   localparam logic [15:0] HALF_M1  = half_bit(16'(CLK_DIV)) - 16'd1;
   localparam logic [2:0]  LAST_BIT = 3'(DATA_W - 1);

   logic rdn_s, rdn_rise_s, rdn_fall_s;
   logic wrn_s, wrn_rise_s, wrn_fall_s;
   logic rxd_s, rxd_rise_s, rxd_fall_s;
   logic unused_s;

   sync_edge #(.RST_VAL(1'b1)) u_sync_rdn (
      .clk_i(CLK), .rst_ni(RST), .d_i(rdn),
      .q_o(rdn_s), .rise_o(rdn_rise_s), .fall_o(rdn_fall_s)
   );
   sync_edge #(.RST_VAL(1'b1)) u_sync_wrn (
      .clk_i(CLK), .rst_ni(RST), .d_i(wrn),
      .q_o(wrn_s), .rise_o(wrn_rise_s), .fall_o(wrn_fall_s)
   );
   sync_edge #(.RST_VAL(1'b1)) u_sync_rxd (
      .clk_i(CLK), .rst_ni(RST), .d_i(rxd),
      .q_o(rxd_s), .rise_o(rxd_rise_s), .fall_o(rxd_fall_s)
   );

   assign unused_s = ^{rdn_s, rdn_fall_s, wrn_fall_s, rxd_rise_s};

   tx_state_t         tx_state_q, tx_state_d;
   logic [15:0]       tx_cnt_q, tx_cnt_d;
   logic [2:0]        tx_bit_q, tx_bit_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_W-1:0] thr_q, thr_d;
   logic [DATA_W-1:0] wr_shadow_q, wr_shadow_d;
   logic              tbre_q, tbre_d;
   logic              tsre_q, tsre_d;
   logic              txd_q, txd_d;
   logic              tx_load_s;

   rx_state_t         rx_state_q, rx_state_d;
   logic [15:0]       rx_cnt_q, rx_cnt_d;
   logic [2:0]        rx_bit_q, rx_bit_d;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_W-1:0] rx_hold_q, rx_hold_d;
   logic              data_ready_q, data_ready_d;
   logic              rx_overrun_q, rx_overrun_d;
   logic              rx_frame_err_q, rx_frame_err_d;
   logic              rx_store_s;

   // Transmit path: write capture, holding register and serializer FSM
   always_comb begin
      tx_state_d  = tx_state_q;
      tx_cnt_d    = tx_cnt_q;
      tx_bit_d    = tx_bit_q;
      tx_shift_d  = tx_shift_q;
      thr_d       = thr_q;
      tbre_d      = tbre_q;
      tsre_d      = tsre_q;
      tx_load_s   = 1'b0;

      if (!wrn_s) begin
         wr_shadow_d = bus_din;
      end else begin
         wr_shadow_d = wr_shadow_q;
      end

      case (tx_state_q)
         TX_IDLE: begin
            if (!tbre_q) begin
               tx_load_s  = 1'b1;
               tx_shift_d = thr_q;
               tsre_d     = 1'b0;
               tx_cnt_d   = DIV_M1;
               tx_state_d = TX_START;
            end else begin
               tx_state_d = TX_IDLE;
            end
         end
         TX_START: begin
            if (tx_cnt_q == 16'd0) begin
               tx_cnt_d   = DIV_M1;
               tx_bit_d   = 3'd0;
               tx_state_d = TX_DATA;
            end else begin
               tx_cnt_d = tx_cnt_q - 16'd1;
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == 16'd0) begin
               tx_cnt_d = DIV_M1;
               if (tx_bit_q == LAST_BIT) begin
                  tx_state_d = TX_STOP;
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  tx_shift_d = tx_shift_q >> 1;
               end
            end else begin
               tx_cnt_d = tx_cnt_q - 16'd1;
            end
         end
         TX_STOP: begin
            if (tx_cnt_q == 16'd0) begin
               // A byte already waiting goes out with no idle gap
               if (!tbre_q) begin
                  tx_load_s  = 1'b1;
                  tx_shift_d = thr_q;
                  tx_cnt_d   = DIV_M1;
                  tx_state_d = TX_START;
               end else begin
                  tsre_d     = 1'b1;
                  tx_state_d = TX_IDLE;
               end
            end else begin
               tx_cnt_d = tx_cnt_q - 16'd1;
            end
         end
         default: begin
            tx_state_d = TX_IDLE;
         end
      endcase

      if (tx_load_s) begin
         tbre_d = 1'b1;
      end else begin
         tbre_d = tbre_q;
      end

      // A commit landing on the load cycle refills the freed holding register
      if (wrn_rise_s && (tbre_q || tx_load_s)) begin
         thr_d  = wr_shadow_q;
         tbre_d = 1'b0;
      end else begin
         thr_d = thr_q;
      end

      case (tx_state_d)
         TX_START: txd_d = 1'b0;
         TX_DATA:  txd_d = tx_shift_d[0];
         default:  txd_d = 1'b1;
      endcase
   end

   // Receive path: deserializer FSM and holding register handshake
   always_comb begin
      rx_state_d     = rx_state_q;
      rx_cnt_d       = rx_cnt_q;
      rx_bit_d       = rx_bit_q;
      rx_shift_d     = rx_shift_q;
      rx_hold_d      = rx_hold_q;
      data_ready_d   = data_ready_q;
      rx_overrun_d   = rx_overrun_q;
      rx_frame_err_d = 1'b0;
      rx_store_s     = 1'b0;

      case (rx_state_q)
         RX_IDLE: begin
            if (rxd_fall_s) begin
               rx_cnt_d   = HALF_M1;
               rx_state_d = RX_START;
            end else begin
               rx_state_d = RX_IDLE;
            end
         end
         RX_START: begin
            if (rx_cnt_q == 16'd0) begin
               if (rxd_s) begin
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_cnt_d   = DIV_M1;
                  rx_bit_d   = 3'd0;
                  rx_state_d = RX_DATA;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - 16'd1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == 16'd0) begin
               rx_cnt_d   = DIV_M1;
               rx_shift_d = {rxd_s, rx_shift_q[DATA_W-1:1]};
               if (rx_bit_q == LAST_BIT) begin
                  rx_state_d = RX_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - 16'd1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == 16'd0) begin
               if (rxd_s) begin
                  rx_store_s = 1'b1;
               end else begin
                  rx_frame_err_d = 1'b1;
               end
               rx_state_d = RX_IDLE;
            end else begin
               rx_cnt_d = rx_cnt_q - 16'd1;
            end
         end
         default: begin
            rx_state_d = RX_IDLE;
         end
      endcase

      if (rdn_rise_s) begin
         data_ready_d = 1'b0;
      end else begin
         data_ready_d = data_ready_q;
      end

      // New byte wins over a same-cycle read; overrun only if nobody read
      if (rx_store_s) begin
         rx_hold_d    = rx_shift_q;
         data_ready_d = 1'b1;
         if (data_ready_q && !rdn_rise_s) begin
            rx_overrun_d = 1'b1;
         end else begin
            rx_overrun_d = rx_overrun_q;
         end
      end else begin
         rx_hold_d = rx_hold_q;
      end
   end

   // State and data registers for both directions
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         tx_state_q     <= TX_IDLE;
         tx_cnt_q       <= 16'd0;
         tx_bit_q       <= 3'd0;
         tx_shift_q     <= '0;
         thr_q          <= '0;
         wr_shadow_q    <= '0;
         tbre_q         <= 1'b1;
         tsre_q         <= 1'b1;
         txd_q          <= 1'b1;
         rx_state_q     <= RX_IDLE;
         rx_cnt_q       <= 16'd0;
         rx_bit_q       <= 3'd0;
         rx_shift_q     <= '0;
         rx_hold_q      <= '0;
         data_ready_q   <= 1'b0;
         rx_overrun_q   <= 1'b0;
         rx_frame_err_q <= 1'b0;
      end else begin
         tx_state_q     <= tx_state_d;
         tx_cnt_q       <= tx_cnt_d;
         tx_bit_q       <= tx_bit_d;
         tx_shift_q     <= tx_shift_d;
         thr_q          <= thr_d;
         wr_shadow_q    <= wr_shadow_d;
         tbre_q         <= tbre_d;
         tsre_q         <= tsre_d;
         txd_q          <= txd_d;
         rx_state_q     <= rx_state_d;
         rx_cnt_q       <= rx_cnt_d;
         rx_bit_q       <= rx_bit_d;
         rx_shift_q     <= rx_shift_d;
         rx_hold_q      <= rx_hold_d;
         data_ready_q   <= data_ready_d;
         rx_overrun_q   <= rx_overrun_d;
         rx_frame_err_q <= rx_frame_err_d;
      end
   end

   assign bus_oe       = ~rdn;
   assign bus_dout     = rx_hold_q;
   assign data_ready   = data_ready_q;
   assign tbre         = tbre_q;
   assign tsre         = tsre_q;
   assign txd          = txd_q;
   assign rx_overrun   = rx_overrun_q;
   assign rx_frame_err = rx_frame_err_q;

endmodule

// File: tb/tb_uart_bus_responder.sv
// Self-checking bench for uart_bus_responder at CLK_DIV=4 with TX/RX scoreboards.
module tb_uart_bus_responder;

   localparam int DIV = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       rdn = 1'b1;
   logic       wrn = 1'b1;
   logic       rxd = 1'b1;
   logic [7:0] bus_din = 8'h00;
   logic [7:0] bus_dout;
   logic       bus_oe, data_ready, tbre, tsre, txd, rx_overrun, rx_frame_err;

   int         checks = 0;
   int         failures = 0;
   int         fe_count = 0;
   bit         mon_en = 1'b0;
   logic [7:0] tx_exp_q[$];
   logic [7:0] rx_exp_q[$];

   uart_bus_responder #(.CLK_DIV(DIV), .DATA_W(8)) dut (
      .CLK(CLK), .RST(RST), .rdn(rdn), .wrn(wrn), .bus_din(bus_din),
      .bus_dout(bus_dout), .bus_oe(bus_oe), .data_ready(data_ready),
      .tbre(tbre), .tsre(tsre), .txd(txd), .rxd(rxd),
      .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (rx_frame_err === 1'b1) fe_count <= fe_count + 1;
   end

   // TX frame decoder: samples near each bit centre and pops the expected byte
   initial begin : tx_monitor
      logic [7:0] got;
      logic [7:0] exp_b;
      forever begin
         @(negedge CLK);
         if (mon_en && RST === 1'b1 && txd === 1'b0) begin
            repeat (2) @(negedge CLK);
            checks++;
            if (txd !== 1'b0) begin
               failures++;
               $display("FAIL tx_start_bit: got %b expected 0", txd);
            end
            for (int i = 0; i < 8; i++) begin
               repeat (DIV) @(negedge CLK);
               got[i] = txd;
            end
            repeat (DIV) @(negedge CLK);
            checks++;
            if (txd !== 1'b1) begin
               failures++;
               $display("FAIL tx_stop_bit: got %b expected 1", txd);
            end
            checks++;
            if (tx_exp_q.size() == 0) begin
               failures++;
               $display("FAIL tx_unexpected: got frame %h expected none", got);
            end else begin
               exp_b = tx_exp_q.pop_front();
               if (got !== exp_b) begin
                  failures++;
                  $display("FAIL tx_byte: got %h expected %h", got, exp_b);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic do_write(input logic [7:0] b);
      @(negedge CLK);
      bus_din = b;
      wrn = 1'b0;
      repeat (6) @(negedge CLK);
      wrn = 1'b1;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_b);
      @(negedge CLK);
      rxd = 1'b0;
      repeat (DIV) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (DIV) @(negedge CLK);
      end
      rxd = stop_b;
      repeat (DIV) @(negedge CLK);
      rxd = 1'b1;
      repeat (3) @(negedge CLK);
   endtask

   task automatic test_reset();
      logic [13:0] exp_v;
      int bad;
      exp_v = {1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge CLK);
         checks++;
         if ({txd, tbre, tsre, data_ready, bus_dout, rx_overrun, rx_frame_err} !== exp_v) begin
            failures++;
            bad++;
            if (bad < 4)
               $display("FAIL reset_idle cycle %0d: got %b expected %b", c,
                        {txd, tbre, tsre, data_ready, bus_dout, rx_overrun, rx_frame_err}, exp_v);
         end
      end
      mon_en = 1'b1;
   endtask

   task automatic test_single_write();
      int found;
      logic [9:0] pat;
      pat = {1'b1, 8'hA5, 1'b0};
      tx_exp_q.push_back(8'hA5);
      do_write(8'hA5);
      found = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge CLK);
         if (tbre === 1'b0) begin
            found = k;
            break;
         end
      end
      checks++;
      if (found < 1 || found > 3) begin
         failures++;
         $display("FAIL tbre_fall_latency: got %0d expected 1..3", found);
      end
      @(negedge CLK);
      checks++;
      if ({tbre, tsre, txd} !== 3'b100) begin
         failures++;
         $display("FAIL tx_load: got tbre/tsre/txd=%b expected 100", {tbre, tsre, txd});
      end
      for (int c = 0; c < 10 * DIV; c++) begin
         if (c > 0) @(negedge CLK);
         checks++;
         if (txd !== pat[c / DIV]) begin
            failures++;
            $display("FAIL tx_wave cycle %0d: got %b expected %b", c, txd, pat[c / DIV]);
         end
      end
      @(negedge CLK);
      checks++;
      if ({tsre, txd} !== 2'b11) begin
         failures++;
         $display("FAIL tx_done: got tsre/txd=%b expected 11", {tsre, txd});
      end
   endtask

   task automatic test_back_to_back();
      tx_exp_q.push_back(8'h55);
      tx_exp_q.push_back(8'h0F);
      fork
         begin
            int g;
            do_write(8'h55);
            g = 0;
            while (!(tbre === 1'b1 && tsre === 1'b0) && g < 20) begin
               @(negedge CLK);
               g++;
            end
            do_write(8'h0F);
            g = 0;
            while (tbre !== 1'b0 && g < 10) begin
               @(negedge CLK);
               g++;
            end
            do_write(8'h99);
            repeat (4) @(negedge CLK);
            checks++;
            if (tbre !== 1'b0) begin
               failures++;
               $display("FAIL b2b_holding: got tbre=%b expected 0", tbre);
            end
         end
         begin
            int n;
            int guard;
            n = 0;
            guard = 0;
            while (tsre !== 1'b0 && guard < 50) begin
               @(negedge CLK);
               guard++;
            end
            while (tsre === 1'b0 && n < 200) begin
               n++;
               @(negedge CLK);
            end
            checks++;
            if (n != 20 * DIV) begin
               failures++;
               $display("FAIL b2b_busy_span: got %0d cycles expected %0d", n, 20 * DIV);
            end
         end
      join
      repeat (60) @(negedge CLK);
      checks++;
      if (tsre !== 1'b1 || tx_exp_q.size() != 0) begin
         failures++;
         $display("FAIL b2b_drain: got tsre=%b pending=%0d expected 1 and 0", tsre, tx_exp_q.size());
      end
   endtask

   task automatic test_rx_read();
      logic [7:0] exp_b;
      int found;
      rx_exp_q.push_back(8'h3C);
      send_rx(8'h3C, 1'b1);
      exp_b = rx_exp_q.pop_front();
      checks++;
      if ({data_ready, bus_dout, rx_overrun} !== {1'b1, exp_b, 1'b0}) begin
         failures++;
         $display("FAIL rx_byte: got dr=%b dout=%h ovr=%b expected 1 %h 0",
                  data_ready, bus_dout, rx_overrun, exp_b);
      end
      checks++;
      if (bus_oe !== 1'b0) begin
         failures++;
         $display("FAIL bus_oe_idle: got %b expected 0", bus_oe);
      end
      @(negedge CLK);
      rdn = 1'b0;
      #1;
      checks++;
      if (bus_oe !== 1'b1) begin
         failures++;
         $display("FAIL bus_oe_read: got %b expected 1", bus_oe);
      end
      repeat (2) @(negedge CLK);
      rdn = 1'b1;
      #1;
      checks++;
      if (bus_oe !== 1'b0) begin
         failures++;
         $display("FAIL bus_oe_release: got %b expected 0", bus_oe);
      end
      found = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge CLK);
         if (data_ready === 1'b0) begin
            found = k;
            break;
         end
      end
      checks++;
      if (found < 1 || found > 3 || bus_dout !== 8'h3C) begin
         failures++;
         $display("FAIL rx_read_clear: got latency=%0d dout=%h expected 1..3 and 3c", found, bus_dout);
      end
   endtask

   task automatic test_rx_overrun();
      logic [7:0] exp_b;
      rx_exp_q.push_back(8'h11);
      send_rx(8'h11, 1'b1);
      exp_b = rx_exp_q.pop_front();
      checks++;
      if ({data_ready, bus_dout, rx_overrun} !== {1'b1, exp_b, 1'b0}) begin
         failures++;
         $display("FAIL rx_first: got dr=%b dout=%h ovr=%b expected 1 %h 0",
                  data_ready, bus_dout, rx_overrun, exp_b);
      end
      rx_exp_q.push_back(8'h22);
      send_rx(8'h22, 1'b1);
      exp_b = rx_exp_q.pop_front();
      checks++;
      if ({data_ready, bus_dout, rx_overrun} !== {1'b1, exp_b, 1'b1}) begin
         failures++;
         $display("FAIL rx_overrun: got dr=%b dout=%h ovr=%b expected 1 %h 1",
                  data_ready, bus_dout, rx_overrun, exp_b);
      end
   endtask

   task automatic test_frame_err();
      int f0;
      f0 = fe_count;
      send_rx(8'h77, 1'b0);
      checks++;
      if (fe_count - f0 != 1) begin
         failures++;
         $display("FAIL frame_err_pulses: got %0d expected 1", fe_count - f0);
      end
      checks++;
      if ({data_ready, bus_dout, rx_frame_err} !== {1'b1, 8'h22, 1'b0}) begin
         failures++;
         $display("FAIL frame_err_hold: got dr=%b dout=%h fe=%b expected 1 22 0",
                  data_ready, bus_dout, rx_frame_err);
      end
   endtask

   task automatic test_glitch();
      int f0;
      @(negedge CLK);
      rdn = 1'b0;
      repeat (2) @(negedge CLK);
      rdn = 1'b1;
      repeat (5) @(negedge CLK);
      f0 = fe_count;
      rxd = 1'b0;
      @(negedge CLK);
      rxd = 1'b1;
      repeat (60) @(negedge CLK);
      checks++;
      if ({data_ready, bus_dout, rx_overrun} !== {1'b0, 8'h22, 1'b1} || fe_count != f0) begin
         failures++;
         $display("FAIL rx_glitch: got dr=%b dout=%h ovr=%b fe=%0d expected 0 22 1 0",
                  data_ready, bus_dout, rx_overrun, fe_count - f0);
      end
   endtask

   task automatic test_reset_mid_tx();
      int g;
      int bad;
      mon_en = 1'b0;
      do_write(8'h00);
      g = 0;
      while (tsre !== 1'b0 && g < 20) begin
         @(negedge CLK);
         g++;
      end
      do_write(8'h3A);
      g = 0;
      while (tbre !== 1'b0 && g < 10) begin
         @(negedge CLK);
         g++;
      end
      checks++;
      if ({txd, tbre, tsre} !== 3'b000) begin
         failures++;
         $display("FAIL pre_reset_busy: got txd/tbre/tsre=%b expected 000", {txd, tbre, tsre});
      end
      #2;
      RST = 1'b0;
      #1;
      checks++;
      if ({txd, tbre, tsre, data_ready, rx_overrun} !== 5'b11100) begin
         failures++;
         $display("FAIL reset_mid_tx: got txd/tbre/tsre/dr/ovr=%b expected 11100",
                  {txd, tbre, tsre, data_ready, rx_overrun});
      end
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge CLK);
         if ({txd, tsre, tbre} !== 3'b111) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL post_reset_quiet: got %0d busy cycles expected 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_back_to_back();
      test_rx_read();
      test_rx_overrun();
      test_frame_err();
      test_glitch();
      test_reset_mid_tx();
      checks++;
      if (tx_exp_q.size() != 0 || rx_exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got tx=%0d rx=%0d pending expected 0 0",
                  tx_exp_q.size(), rx_exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
